// File: rtl/sim_status_mon.sv
// rtl/sim_status_mon.sv - Snoops SW status writes into per-channel verdicts, an end-of-test flag and an event FIFO
module sim_status_mon #(
  parameter int unsigned NumCh         = 4,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned EvtDepth      = 8,
  parameter int unsigned TimeoutCycles = 0,
  parameter bit          FailFast      = 1'b1,
  parameter logic [15:0] CodeInTest    = 16'h4354,
  parameter logic [15:0] CodePass      = 16'h900d,
  parameter logic [15:0] CodeFail      = 16'hbaad
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [AddrWidth-1:0]   base_addr_i,
  input  logic                   wr_valid_i,
  input  logic [AddrWidth-1:0]   wr_addr_i,
  input  logic [DataWidth-1:0]   wr_data_i,
  output logic [2*NumCh-1:0]     ch_state_o,
  output logic                   done_o,
  output logic                   passed_o,
  output logic                   timeout_o,
  output logic                   evt_valid_o,
  input  logic                   evt_ready_i,
  output logic [3:0]             evt_ch_o,
  output logic [15:0]            evt_code_o,
  output logic [7:0]             evt_drop_o
);
  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_RUN = 2'b01, ST_PASS = 2'b10, ST_FAIL = 2'b11} ch_state_e;

  localparam int unsigned PtrW = (EvtDepth > 1) ? $clog2(EvtDepth) : 1;
  localparam logic [AddrWidth-1:0] Span = AddrWidth'(4 * NumCh);

  ch_state_e             ch_q [NumCh];
  ch_state_e             ch_d [NumCh];
  logic                  done_q, done_d, timeout_q, expire;
  logic [AddrWidth-1:0]  offset;
  logic [3:0]            wr_ch;
  logic [15:0]           wr_code;
  logic                  hit, accept, all_term_d, fail_now, all_pass;
  logic [3:0]            mem_ch   [EvtDepth];
  logic [15:0]           mem_code [EvtDepth];
  logic [PtrW-1:0]       rd_q, wr_q;
  logic [PtrW:0]         cnt_q;
  logic [3:0]            last_ch_q;
  logic [15:0]           last_code_q;
  logic [7:0]            drop_q;
  logic                  full, pop, push, drop_inc;
  logic                  unused_bits;

  // The explicit >= check rejects addresses that only match after the subtraction wraps.
  assign offset      = wr_addr_i - base_addr_i;
  assign hit         = wr_valid_i && (wr_addr_i[1:0] == 2'b00) && (wr_addr_i >= base_addr_i) && (offset < Span);
  assign accept      = hit && !done_q;
  assign wr_ch       = offset[5:2];
  assign wr_code     = wr_data_i[15:0];
  assign unused_bits = ^{wr_data_i, offset};

  always_comb begin
    fail_now   = 1'b0;
    all_term_d = 1'b1;
    all_pass   = 1'b1;
    ch_state_o = '0;
    for (int n = 0; n < NumCh; n++) begin
      ch_d[n] = ch_q[n];
      if (accept && wr_ch == 4'(n) && (ch_q[n] == ST_IDLE || ch_q[n] == ST_RUN)) begin
        if (wr_code == CodePass) begin
          ch_d[n] = ST_PASS;
        end else if (wr_code == CodeFail) begin
          ch_d[n]  = ST_FAIL;
          fail_now = 1'b1;
        end else if (wr_code == CodeInTest && ch_q[n] == ST_IDLE) begin
          ch_d[n] = ST_RUN;
        end
      end
      if (ch_d[n] != ST_PASS && ch_d[n] != ST_FAIL) all_term_d = 1'b0;
      if (ch_q[n] != ST_PASS) all_pass = 1'b0;
      ch_state_o[2*n +: 2] = ch_q[n];
    end
    done_d = done_q || expire || (accept && (all_term_d || (FailFast && fail_now)));
  end

  generate
    if (TimeoutCycles > 0) begin : g_wd
      localparam int unsigned WdW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
      logic [WdW-1:0] wd_q, wd_d;
      // A write in the expiry cycle clears the count instead of timing out.
      assign expire = !done_q && !accept && (wd_q == WdW'(TimeoutCycles - 1));
      always_comb begin
        wd_d = wd_q;
        if (accept)       wd_d = '0;
        else if (!done_q) wd_d = wd_q + 1'b1;
      end
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) wd_q <= '0;
        else         wd_q <= wd_d;
      end
    end else begin : g_no_wd
      assign expire = 1'b0;
    end
  endgenerate

  assign full        = (cnt_q == (PtrW+1)'(EvtDepth));
  assign evt_valid_o = (cnt_q != '0);
  assign pop         = evt_valid_o && evt_ready_i;
  assign push        = accept && (!full || pop);
  assign drop_inc    = accept && full && !pop;
  // When empty the head shows the most recently popped event.
  assign evt_ch_o    = evt_valid_o ? mem_ch[rd_q]   : last_ch_q;
  assign evt_code_o  = evt_valid_o ? mem_code[rd_q] : last_code_q;
  assign evt_drop_o  = drop_q;
  assign done_o      = done_q;
  assign timeout_o   = timeout_q;
  assign passed_o    = done_q && all_pass && !timeout_q;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_ch[wr_q]   <= wr_ch;
      mem_code[wr_q] <= wr_code;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int n = 0; n < NumCh; n++) ch_q[n] <= ST_IDLE;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      rd_q        <= '0;
      wr_q        <= '0;
      cnt_q       <= '0;
      last_ch_q   <= '0;
      last_code_q <= '0;
      drop_q      <= '0;
    end else begin
      ch_q      <= ch_d;
      done_q    <= done_d;
      timeout_q <= timeout_q | expire;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) begin
        rd_q        <= rd_q + 1'b1;
        last_ch_q   <= mem_ch[rd_q];
        last_code_q <= mem_code[rd_q];
      end
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
      if (drop_inc && drop_q != 8'hff) drop_q <= drop_q + 1'b1;
    end
  end
endmodule

// File: doc/sim_status_mon.md
SIM_STATUS_MON -- requirements
Module: sim_status_mon

Interface
- REQ-001: The block SHALL take parameter NumCh, default 4: number of independent SW test status channels, range 1..16.
- REQ-002: The block SHALL take parameter AddrWidth, default 32: bus address width.
- REQ-003: The block SHALL take parameter DataWidth, default 32: bus write data width.
- REQ-004: The block SHALL take parameter EvtDepth, default 8: event FIFO depth, power of two, at least 2.
- REQ-005: The block SHALL take parameter TimeoutCycles, default 0: inactivity watchdog limit; 0 disables the watchdog.
- REQ-006: The block SHALL take parameter FailFast, default 1: when 1, any channel failure ends the test.
- REQ-007: The block SHALL take parameters CodeInTest, CodePass and CodeFail, 16 bits each, defaults 16'h4354, 16'h900d and 16'h baad.
- REQ-008: clk_i  in  1  sole clock; one clock, all logic on its rising edge.
- REQ-009: rst_ni  in  1  reset, asynchronous, active-low.
- REQ-010: base_addr_i  in  AddrWidth  address of the channel 0 status word; quasi-static.
- REQ-011: wr_valid_i  in  1  single-cycle pulse qualifying an observed bus write.
- REQ-012: wr_addr_i  in  AddrWidth  observed write address.
- REQ-013: wr_data_i  in  DataWidth  observed write data; bits [15:0] carry the status code.
- REQ-014: ch_state_o  out  2*NumCh  per-channel state, channel n at bits [2n+1:2n].
- REQ-015: done_o  out  1  sticky end-of-test flag.
- REQ-016: passed_o  out  1  verdict; valid only while done_o is high.
- REQ-017: timeout_o  out  1  sticky flag; high when the watchdog ended the test.
- REQ-018: evt_valid_o / evt_ready_i  out / in  1 / 1  event FIFO handshake.
- REQ-019: evt_ch_o  out  4  channel index of the head event.
- REQ-020: evt_code_o  out  16  status code of the head event.
- REQ-021: evt_drop_o  out  8  saturating count of dropped events.

Function
- REQ-022: A write SHALL be decoded when wr_valid_i=1, wr_addr_i[1:0]=0, and base_addr_i <= wr_addr_i < base_addr_i+4*NumCh; the channel index is (wr_addr_i-base_addr_i)>>2. The subtraction is unsigned, AddrWidth bits wide, with no wrap-around match.
- REQ-023: Channel state encoding: IDLE=00, RUN=01, PASS=10, FAIL=11.
- REQ-024: Channel transitions:
  - IDLE on CodeInTest: to RUN.
  - IDLE or RUN on CodePass: to PASS.
  - IDLE or RUN on CodeFail: to FAIL.
  - Any other code: no change.
  - PASS and FAIL are terminal until reset.
- REQ-025: A state update SHALL be visible on ch_state_o one cycle after the decoded write.
- REQ-026: done_o SHALL rise one cycle after the decoded write that does either of the following:
  - makes all channels terminal;
  - with FailFast=1, moves any channel to FAIL.
- REQ-027: While done_o=1, decoded writes SHALL NOT change state, push events, or clear the watchdog.
- REQ-028: passed_o SHALL be 1 iff done_o=1, every channel is PASS, and timeout_o=0.
- REQ-029: Watchdog (TimeoutCycles>0):
  - The counter increments every cycle while done_o=0.
  - Any decoded write clears it to 0.
  - When the counter equals TimeoutCycles-1 with no decoded write that cycle, timeout_o and done_o SHALL both rise the next cycle.
  - When a decoded write and expiry occur in the same cycle, the write wins.
- REQ-030: Every decoded write accepted under REQ-027 SHALL push {channel, code} into the FIFO, including unknown codes.
- REQ-031: A pushed event SHALL appear at the FIFO head with evt_valid_o=1 one cycle after the push.
- REQ-032: A pop SHALL occur when evt_valid_o and evt_ready_i are both 1; events SHALL pop in push order.
- REQ-033: On push while full: if a pop occurs the same cycle, the push is accepted; otherwise the push is dropped and evt_drop_o increments, saturating at 255.
- REQ-034: When the FIFO is empty, evt_valid_o=0, and evt_ch_o and evt_code_o SHALL hold their last values.

Reset
- REQ-035: Asserting rst_ni low SHALL asynchronously force the following, including mid-operation:
  - all channels to IDLE;
  - done_o, passed_o, timeout_o to 0;
  - the FIFO to empty, evt_valid_o=0;
  - evt_ch_o, evt_code_o, evt_drop_o and the watchdog counter to 0.
- REQ-036: After rst_ni deasserts, the watchdog SHALL start counting on the first rising clock edge.

Verification
- REQ-037: Pass path. NumCh=2, base 0x1000_0000. Write 0x4354 to ch0 and ch1, then 0x900d to ch0 and ch1 -> done_o=1 and passed_o=1 one cycle after the last write; ch_state_o=4'b1010.
- REQ-038: Fail-fast. NumCh=4, FailFast=1. Write 0xbaad to ch2 -> next cycle ch_state_o[5:4]=11, done_o=1, passed_o=0. A later 0x900d to ch0 leaves ch0 IDLE.
- REQ-039: Watchdog. TimeoutCycles=10, no writes after reset -> timeout_o=done_o=1 exactly 10 cycles after the first clock edge. A write at cycle 9 restarts the count instead.
- REQ-040: FIFO overflow. EvtDepth=4, evt_ready_i=0, 6 writes -> 4 events held, evt_drop_o=2. Raising evt_ready_i then pops the 4 events in order. A full push and pop in the same cycle drops nothing.
- REQ-041: Decode boundaries. Writes to base-4, base+4*NumCh and base+2 -> no state change and no event. A write to base+4*(NumCh-1) -> decoded to the last channel.
- REQ-042: Reset mid-test. Assert rst_ni with 3 events queued and ch0 in RUN -> all outputs return to 0 asynchronously, before the next clock edge.
